// File: rtl/cell_fifo_pkg.sv
// Shared definitions for the cell FIFO read and write sides: default widths,
// output-buffer entry layout and the CELL_LEN legality check.
package cell_fifo_pkg;

    localparam int unsigned DWIDTH_DEF = 8;
    localparam int unsigned CWIDTH_DEF = 2;

    // Buffer entry layout at the default width; wider builds keep the same field order.
    typedef struct packed {
        logic [DWIDTH_DEF-1:0] data;
        logic                  sop;
        logic                  eop;
    } obuf_entry_t;

    localparam int unsigned OBUF_ENTRY_W = $bits(obuf_entry_t);

    function automatic int unsigned entry_w(input int unsigned dw);
        return dw + 32'd2;
    endfunction

    function automatic bit cell_len_ok(input int unsigned len, input int unsigned cw);
        return (len >= 32'd2) && (len <= (32'd1 << cw));
    endfunction

endpackage

// File: rtl/cell_fifo_rd_ctrl_if.sv
// FIFO read-port and downstream word-stream signals of the cell FIFO read controller.
interface cell_fifo_rd_ctrl_if
    import cell_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned CWIDTH = CWIDTH_DEF
);
    logic              i_fifo_empty;
    logic              o_fifo_ren;
    logic              o_fifo_reoc;
    logic [CWIDTH-1:0] o_fifo_raddr;
    logic [DWIDTH-1:0] i_fifo_rdata;
    logic              o_valid;
    logic              i_ready;
    logic [DWIDTH-1:0] o_data;
    logic              o_sop;
    logic              o_eop;

    modport master (
        input  i_fifo_empty, i_fifo_rdata, i_ready,
        output o_fifo_ren, o_fifo_reoc, o_fifo_raddr, o_valid, o_data, o_sop, o_eop
    );

    modport slave (
        output i_fifo_empty, i_fifo_rdata, i_ready,
        input  o_fifo_ren, o_fifo_reoc, o_fifo_raddr, o_valid, o_data, o_sop, o_eop
    );
endinterface

// File: rtl/cell_rd_obuf.sv
// Two-entry in-order output buffer; entry 0 is always the head.
module cell_rd_obuf #(
    parameter int unsigned EW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [EW-1:0] i_din,
    input  logic          i_pop,
    output logic [EW-1:0] o_head,
    output logic [1:0]    o_occ
);
    logic [EW-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]    occ_q, occ_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    // Simultaneous push/pop shifts the tail forward and lands the new word behind it.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({i_push, i_pop})
            2'b10: begin
                if (occ_q == 2'd0) e0_d = i_din;
                else               e1_d = i_din;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    e0_d = i_din;
                end else begin
                    e0_d = e1_q;
                    e1_d = i_din;
                end
            end
            default: ;
        endcase
    end

    assign o_head = e0_q;
    assign o_occ  = occ_q;
endmodule

// File: rtl/cell_fifo_rd_ctrl.sv
// Drains whole cells from the cell FIFO pre-read port into a valid/ready word stream.
// Optional delivered-cell counter enabled by CELL_FIFO_RD_STATS_EN.
module cell_fifo_rd_ctrl
    import cell_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH   = DWIDTH_DEF,
    parameter int unsigned CWIDTH   = CWIDTH_DEF,
    parameter int unsigned CELL_LEN = 4,
    parameter int          U_DLY    = 1
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst,
    cell_fifo_rd_ctrl_if.master   bus,
    output logic [31:0]           o_cell_cnt
);
    localparam int unsigned       EW       = entry_w(DWIDTH);
    localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(CELL_LEN - 1);

    if (!cell_len_ok(CELL_LEN, CWIDTH) || (U_DLY < 0) ||
        ((DWIDTH == DWIDTH_DEF) && (EW != OBUF_ENTRY_W))) begin : g_cfg_err
        $error("cell_fifo_rd_ctrl: illegal CELL_LEN/CWIDTH/U_DLY configuration");
    end

    logic [CWIDTH-1:0] widx_q, widx_d;
    logic [1:0]        occ;
    logic              ren_c, pop_c, last_c;
    logic [EW-1:0]     push_entry, head_entry;

    // Gate on buffer occupancy only, so i_ready never reaches the FIFO read enable.
    assign ren_c  = !bus.i_fifo_empty && (occ < 2'd2);
    assign last_c = (widx_q == LAST_IDX);
    assign pop_c  = bus.o_valid && bus.i_ready;

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) widx_q <= '0;
        else       widx_q <= widx_d;
    end

    always_comb begin
        widx_d = widx_q;
        if (ren_c) widx_d = last_c ? '0 : widx_q + CWIDTH'(1);
    end

    assign push_entry = {bus.i_fifo_rdata, (widx_q == '0), last_c};

    cell_rd_obuf #(.EW(EW)) u_obuf (
        .i_clk  (i_clk_sys),
        .i_rst  (i_rst),
        .i_push (ren_c),
        .i_din  (push_entry),
        .i_pop  (pop_c),
        .o_head (head_entry),
        .o_occ  (occ)
    );

    assign bus.o_fifo_ren   = ren_c;
    assign bus.o_fifo_reoc  = ren_c && last_c;
    assign bus.o_fifo_raddr = widx_q;
    assign bus.o_valid      = (occ != 2'd0);
    assign bus.o_data       = head_entry[EW-1:2];
    assign bus.o_sop        = head_entry[1];
    assign bus.o_eop        = head_entry[0];

`ifdef CELL_FIFO_RD_STATS_EN
    logic [31:0] cell_cnt_q;

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst)                      cell_cnt_q <= 32'd0;
        else if (pop_c && bus.o_eop)    cell_cnt_q <= cell_cnt_q + 32'd1;
    end

    assign o_cell_cnt = cell_cnt_q;
`else
    assign o_cell_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_cell_fifo_rd_ctrl.sv
// Self-checking bench for cell_fifo_rd_ctrl: behavioural cell FIFO plus a word-stream scoreboard.
module tb_cell_fifo_rd_ctrl;
    import cell_fifo_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 2;
    localparam int unsigned CL = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cell_cnt;

    cell_fifo_rd_ctrl_if #(.DWIDTH(DW), .CWIDTH(CW)) bus ();

    cell_fifo_rd_ctrl #(.DWIDTH(DW), .CWIDTH(CW), .CELL_LEN(CL), .U_DLY(1)) dut (
        .i_clk_sys  (clk),
        .i_rst      (rst),
        .bus        (bus),
        .o_cell_cnt (cell_cnt)
    );

    always #5 clk = ~clk;

    // Cell FIFO: whole cells only, read pointer advances on the read end-of-cell.
    logic [DW-1:0] mem [0:255];
    int            wr_cells = 0;
    int            rd_cells = 0;
    logic [7:0]    rd_addr;

    assign rd_addr          = {rd_cells[5:0], bus.o_fifo_raddr};
    assign bus.i_fifo_empty = (wr_cells == rd_cells);
    assign bus.i_fifo_rdata = mem[rd_addr];

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   words_read = 0, words_popped = 0, cells_popped = 0;
    int   n_ren, n_reoc, n_pop, first_pop, last_pop, full_ticks;
    int   tick_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_cell(input logic [DW-1:0] base, input bit rnd);
        logic [DW-1:0] d;
        for (int w = 0; w < CL; w++) begin
            d = rnd ? DW'($urandom) : base + DW'(w);
            mem[8'({wr_cells[5:0], CW'(w)})] = d;
            exp_q.push_back('{d: d, s: (w == 0), e: (w == CL - 1)});
        end
        wr_cells++;
    endtask

    task automatic sec_start();
        n_ren = 0; n_reoc = 0; n_pop = 0;
        first_pop = -1; last_pop = -1; full_ticks = 0;
    endtask

    // One clock: check the pre-edge view against the model, then advance the model past the edge.
    task automatic tick();
        logic ren, reoc, pop, exp_ren;
        int   outst;
        @(negedge clk); #1;
        outst   = words_read - words_popped;
        exp_ren = (wr_cells != rd_cells) && (outst < 2);
        ren     = bus.o_fifo_ren;
        reoc    = bus.o_fifo_reoc;
        chk("ren", 32'(ren), 32'(exp_ren));
        if (ren) begin
            chk("raddr", 32'(bus.o_fifo_raddr), 32'(words_read % CL));
            chk("reoc", 32'(reoc), 32'((words_read % CL) == CL - 1));
        end else begin
            chk("reoc_idle", 32'(reoc), 32'd0);
        end
        chk("valid", 32'(bus.o_valid), 32'(outst != 0));
        if (bus.o_valid && exp_q.size() != 0) begin
            chk("data", 32'(bus.o_data), 32'(exp_q[0].d));
            chk("sop", 32'(bus.o_sop), 32'(exp_q[0].s));
            chk("eop", 32'(bus.o_eop), 32'(exp_q[0].e));
        end
`ifdef CELL_FIFO_RD_STATS_EN
        chk("cell_cnt", cell_cnt, 32'(cells_popped));
`else
        chk("cell_cnt", cell_cnt, 32'd0);
`endif
        pop = bus.o_valid && bus.i_ready;
        if (outst == 2) full_ticks++;
        @(posedge clk); #1;
        if (ren)  begin words_read++; n_ren++; end
        if (reoc) begin rd_cells++;   n_reoc++; end
        if (pop && exp_q.size() != 0) begin
            if (exp_q[0].e) cells_popped++;
            void'(exp_q.pop_front());
            words_popped++;
            n_pop++;
            if (first_pop < 0) first_pop = tick_no;
            last_pop = tick_no;
        end
        tick_no++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        wr_cells = 0; rd_cells = 0;
        words_read = 0; words_popped = 0; cells_popped = 0;
        exp_q.delete();
        #1;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_data",  32'(bus.o_data),  32'd0);
        chk("rst_sop",   32'(bus.o_sop),   32'd0);
        chk("rst_eop",   32'(bus.o_eop),   32'd0);
        chk("rst_ren",   32'(bus.o_fifo_ren),   32'd0);
        chk("rst_reoc",  32'(bus.o_fifo_reoc),  32'd0);
        chk("rst_raddr", 32'(bus.o_fifo_raddr), 32'd0);
        chk("rst_cnt",   cell_cnt, 32'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.i_ready = 1'b0;
        rst = 1'b1;
        apply_reset();

        // Single cell with ready held high.
        sec_start();
        bus.i_ready = 1'b1;
        write_cell(8'hA0, 1'b0);
        repeat (6) tick();
        chk("a_ren_cnt",  32'(n_ren),  32'd4);
        chk("a_reoc_cnt", 32'(n_reoc), 32'd1);
        chk("a_beats",    32'(n_pop),  32'd4);
        chk("a_consec",   32'(last_pop - first_pop), 32'd3);

        // Two cells back to back: eight beats without a bubble.
        sec_start();
        write_cell(8'hB0, 1'b0);
        write_cell(8'hC0, 1'b0);
        repeat (11) tick();
        chk("b2b_beats",  32'(n_pop),  32'd8);
        chk("b2b_consec", 32'(last_pop - first_pop), 32'd7);
        chk("b2b_reoc",   32'(n_reoc), 32'd2);

        // Backpressure from word 1 for three cycles.
        sec_start();
        write_cell(8'hD0, 1'b0);
        tick();
        tick();
        bus.i_ready = 1'b0;
        repeat (3) tick();
        bus.i_ready = 1'b1;
        repeat (6) tick();
        chk("bp_beats", 32'(n_pop), 32'd4);
        chk("bp_ren",   32'(n_ren), 32'd4);
        chk("bp_full",  32'(full_ticks), 32'd3);

        // FIFO empty throughout.
        sec_start();
        for (int i = 0; i < 20; i++) begin
            bus.i_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("empty_ren",   32'(n_ren), 32'd0);
        chk("empty_beats", 32'(n_pop), 32'd0);

        // Reset after word 2 of a cell, then a fresh cell.
        bus.i_ready = 1'b1;
        write_cell(8'hE0, 1'b0);
        repeat (3) tick();
        apply_reset();
        sec_start();
        write_cell(8'hF0, 1'b0);
        repeat (6) tick();
        chk("post_rst_beats", 32'(n_pop), 32'd4);

        // Five cells drained.
        apply_reset();
        sec_start();
        for (int c = 0; c < 5; c++) write_cell(8'(8'h10 * c), 1'b0);
        repeat (25) tick();
        chk("five_beats", 32'(n_pop), 32'd20);
`ifdef CELL_FIFO_RD_STATS_EN
        chk("five_cnt", cell_cnt, 32'd5);
`else
        chk("five_cnt", cell_cnt, 32'd0);
`endif

        // Random arrivals and random backpressure.
        for (int i = 0; i < 400; i++) begin
            bus.i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0 && (wr_cells - rd_cells) < 8) write_cell(8'h00, 1'b1);
            tick();
        end
        bus.i_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        chk("drain_left", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
